// File: rtl/reg_bus_fabric_if.sv
// CPU-side register/memory bus: address, write data, strobes, read data and stall.
interface reg_bus_fabric_if;
    logic [15:0] bus_address;
    logic [7:0]  bus_data_tx;
    logic [7:0]  bus_data_rx;
    logic        bus_read;
    logic        bus_write;
    logic        bus_wait;

    modport master (
        output bus_address, bus_data_tx, bus_read, bus_write,
        input  bus_data_rx, bus_wait
    );

    modport slave (
        input  bus_address, bus_data_tx, bus_read, bus_write,
        output bus_data_rx, bus_wait
    );
endinterface

// File: rtl/reg_bus_fabric.sv
// Register-page interconnect: decodes REG_PAGE into 16-byte peripheral slots, forwards
// everything else to memory, and aborts slot accesses that stall beyond TIMEOUT_CYCLES.
module reg_bus_fabric #(
    parameter int         NUM_SLOTS      = 4,
    parameter logic [7:0] REG_PAGE       = 8'hFF,
    parameter int         TIMEOUT_CYCLES = 1024,
    parameter int         CNT_WIDTH      = 11
) (
    input  logic                   clk,
    input  logic                   rst_n,
    reg_bus_fabric_if.slave        bus,
    output logic                   mem_read,
    output logic                   mem_write,
    input  logic [7:0]             mem_data_rx,
    input  logic                   mem_wait,
    output logic [3:0]             slv_address,
    output logic [7:0]             slv_data_tx,
    output logic [NUM_SLOTS-1:0]   slv_read,
    output logic [NUM_SLOTS-1:0]   slv_write,
    input  logic [8*NUM_SLOTS-1:0] slv_data_rx,
    input  logic [NUM_SLOTS-1:0]   slv_wait,
    output logic                   err_irq
);
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_WAITING = 2'd1;
    localparam logic [1:0] ST_ABORT   = 2'd2;
    localparam logic [CNT_WIDTH-1:0] CNT_LIMIT = CNT_WIDTH'(TIMEOUT_CYCLES);

    logic [1:0]           state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [7:0]           status_q, status_d;
    logic [7:0]           tocount_q, tocount_d;
    logic                 err_irq_q, err_irq_d;

    logic       wr_stb, rd_stb, any_stb;
    logic       reg_sel, slot_hit, stat_sel, unmapped, abort;
    logic       slot_stb, timeout_evt;
    logic [3:0] slot;
    logic [7:0] sel_rx;
    logic       sel_wait;

    // Read+write together is a write, so the read strobe is masked by write.
    always_comb begin
        wr_stb   = bus.bus_write;
        rd_stb   = bus.bus_read & ~bus.bus_write;
        any_stb  = wr_stb | rd_stb;
        slot     = bus.bus_address[7:4];
        reg_sel  = (bus.bus_address[15:8] == REG_PAGE);
        slot_hit = reg_sel && (32'(slot) < 32'(NUM_SLOTS));
        stat_sel = reg_sel && (slot == 4'hF);
        unmapped = reg_sel && !slot_hit && !stat_sel;
        abort    = (state_q == ST_ABORT);
        slot_stb = slot_hit && any_stb;
    end

    always_comb begin
        sel_rx   = 8'h00;
        sel_wait = 1'b0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (slot == 4'(i)) begin
                sel_rx   = slv_data_rx[8*i +: 8];
                sel_wait = slv_wait[i];
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
            assign slv_read[gi]  = slot_hit && (slot == 4'(gi)) && rd_stb && !abort;
            assign slv_write[gi] = slot_hit && (slot == 4'(gi)) && wr_stb && !abort;
        end
    endgenerate

    assign mem_read    = !reg_sel && rd_stb;
    assign mem_write   = !reg_sel && wr_stb;
    assign slv_address = bus.bus_address[3:0];
    assign slv_data_tx = bus.bus_data_tx;
    assign err_irq     = err_irq_q;

    // The abort cycle overrides every source so the CPU is released with 8'hFF.
    always_comb begin
        bus.bus_data_rx = 8'hFF;
        bus.bus_wait    = 1'b0;
        if (abort) begin
            bus.bus_data_rx = 8'hFF;
            bus.bus_wait    = 1'b0;
        end else if (!reg_sel) begin
            bus.bus_data_rx = mem_data_rx;
            bus.bus_wait    = mem_wait;
        end else if (slot_hit) begin
            bus.bus_data_rx = sel_rx;
            bus.bus_wait    = sel_wait;
        end else if (stat_sel) begin
            case (bus.bus_address[3:0])
                4'h0:    bus.bus_data_rx = status_q;
                4'h1:    bus.bus_data_rx = tocount_q;
                default: bus.bus_data_rx = 8'h00;
            endcase
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        timeout_evt = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (slot_stb && sel_wait) begin
                    state_d = ST_WAITING;
                    cnt_d   = CNT_WIDTH'(1);
                end
            end
            ST_WAITING: begin
                if (!slot_stb || !sel_wait) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LIMIT) begin
                    state_d     = ST_ABORT;
                    cnt_d       = '0;
                    timeout_evt = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Clears are applied first so that a simultaneous set takes precedence.
    always_comb begin
        status_d  = status_q;
        tocount_d = tocount_q;
        if (stat_sel && wr_stb && bus.bus_address[3:0] == 4'h0)
            status_d[1:0] = status_q[1:0] & ~bus.bus_data_tx[1:0];
        if (stat_sel && wr_stb && bus.bus_address[3:0] == 4'h1)
            tocount_d = 8'h00;
        if (unmapped && any_stb)
            status_d[1] = 1'b1;
        if (timeout_evt) begin
            status_d[0]   = 1'b1;
            status_d[7:4] = slot;
            if (tocount_d != 8'hFF)
                tocount_d = tocount_d + 8'h01;
        end
        err_irq_d = |status_d[1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            status_q  <= 8'h00;
            tocount_q <= 8'h00;
            err_irq_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            status_q  <= status_d;
            tocount_q <= tocount_d;
            err_irq_q <= err_irq_d;
        end
    end
endmodule

// File: tb/tb_reg_bus_fabric.sv
// Randomised bench for reg_bus_fabric; a transaction-level model predicts stalls, strobes,
// read data and the sticky status registers.
module tb_reg_bus_fabric;
    localparam int NS = 4;
    localparam int TO = 8;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic            mem_read, mem_write, mem_wait;
    logic [7:0]      mem_data_rx;
    logic [3:0]      slv_address;
    logic [7:0]      slv_data_tx;
    logic [NS-1:0]   slv_read, slv_write, slv_wait;
    logic [8*NS-1:0] slv_data_rx;
    logic            err_irq;

    int checks = 0;
    int failures = 0;

    // Model of the status block.
    bit         m_to, m_unm;
    logic [3:0] m_last;
    int         m_tocount;

    reg_bus_fabric_if bus ();

    reg_bus_fabric #(
        .NUM_SLOTS(NS), .REG_PAGE(8'hFF), .TIMEOUT_CYCLES(TO), .CNT_WIDTH(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .mem_read(mem_read), .mem_write(mem_write), .mem_data_rx(mem_data_rx), .mem_wait(mem_wait),
        .slv_address(slv_address), .slv_data_tx(slv_data_tx),
        .slv_read(slv_read), .slv_write(slv_write), .slv_data_rx(slv_data_rx), .slv_wait(slv_wait),
        .err_irq(err_irq)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] exp_status();
        return {m_last, 2'b00, m_unm, m_to};
    endfunction

    function automatic void model_reset();
        m_to = 0; m_unm = 0; m_last = 4'h0; m_tocount = 0;
    endfunction

    // op: 0 read, 1 write, 2 read+write (acts as write). n_stall: cycles the target holds wait.
    task automatic run_txn(input logic [15:0] a, input int op, input logic [7:0] wd,
                           input int n_stall, input string tag);
        bit is_wr, is_reg, is_slot, is_stat, is_unm, timed_out, exp_wait, ab, done;
        int sl, cyc;
        logic [NS-1:0] exp_sr, exp_sw;
        logic [1:0] exp_mem;
        logic [7:0] exp_rx;
        is_wr     = (op != 0);
        is_reg    = (a[15:8] == 8'hFF);
        sl        = int'(a[7:4]);
        is_slot   = is_reg && sl < NS;
        is_stat   = is_reg && sl == 15;
        is_unm    = is_reg && !is_slot && !is_stat;
        timed_out = is_slot && n_stall > TO;
        bus.bus_address = a;
        bus.bus_data_tx = wd;
        bus.bus_read    = (op != 1);
        bus.bus_write   = is_wr;
        mem_data_rx     = 8'($urandom);
        slv_data_rx     = (8*NS)'($urandom);
        $display("txn %s addr=%h op=%0d wd=%h stall=%0d", tag, a, op, wd, n_stall);
        cyc = 0;
        done = 0;
        while (!done) begin
            slv_wait = NS'($urandom);
            mem_wait = 1'($urandom);
            if (!is_reg) mem_wait = (cyc < n_stall);
            if (is_slot) slv_wait[sl] = (cyc < n_stall);
            @(negedge clk);
            exp_wait = timed_out ? (cyc <= TO) : ((is_slot || !is_reg) && cyc < n_stall);
            ab = timed_out && cyc == TO + 1;
            exp_sr = '0;
            exp_sw = '0;
            if (is_slot && !ab) begin
                if (is_wr) exp_sw[sl] = 1'b1;
                else       exp_sr[sl] = 1'b1;
            end
            exp_mem = is_reg ? 2'b00 : (is_wr ? 2'b01 : 2'b10);
            checks++;
            if (bus.bus_wait !== exp_wait) begin
                failures++;
                $display("FAIL %s bus_wait cyc=%0d got=%b exp=%b", tag, cyc, bus.bus_wait, exp_wait);
            end
            checks++;
            if ({slv_read, slv_write} !== {exp_sr, exp_sw}) begin
                failures++;
                $display("FAIL %s slv_strobes cyc=%0d got=%b/%b exp=%b/%b", tag, cyc,
                         slv_read, slv_write, exp_sr, exp_sw);
            end
            checks++;
            if ({mem_read, mem_write} !== exp_mem) begin
                failures++;
                $display("FAIL %s mem_strobes cyc=%0d got=%b exp=%b", tag, cyc, {mem_read, mem_write}, exp_mem);
            end
            checks++;
            if ({slv_address, slv_data_tx} !== {a[3:0], wd}) begin
                failures++;
                $display("FAIL %s slv_addr_data got=%h/%h exp=%h/%h", tag, slv_address, slv_data_tx, a[3:0], wd);
            end
            if (!exp_wait) begin
                done = 1;
                if (!is_wr) begin
                    if (ab || is_unm)   exp_rx = 8'hFF;
                    else if (!is_reg)   exp_rx = mem_data_rx;
                    else if (is_slot)   exp_rx = slv_data_rx[8*sl +: 8];
                    else if (a[3:0] == 4'h0) exp_rx = exp_status();
                    else if (a[3:0] == 4'h1) exp_rx = 8'(m_tocount);
                    else                exp_rx = 8'h00;
                    checks++;
                    if (bus.bus_data_rx !== exp_rx) begin
                        failures++;
                        $display("FAIL %s rx got=%h exp=%h", tag, bus.bus_data_rx, exp_rx);
                    end
                end
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        bus.bus_read  = 1'b0;
        bus.bus_write = 1'b0;
        if (timed_out) begin
            m_to = 1;
            m_last = a[7:4];
            if (m_tocount < 255) m_tocount++;
        end
        if (is_unm) m_unm = 1;
        if (is_stat && is_wr && a[3:0] == 4'h0) begin
            if (wd[0]) m_to = 0;
            if (wd[1]) m_unm = 0;
        end
        if (is_stat && is_wr && a[3:0] == 4'h1) m_tocount = 0;
        @(negedge clk);
        checks++;
        if ({err_irq, slv_read, slv_write, mem_read, mem_write} !== {m_to | m_unm, {(2*NS+2){1'b0}}}) begin
            failures++;
            $display("FAIL %s idle err_irq/strobes got=%b/%b%b%b%b exp_irq=%b", tag, err_irq,
                     slv_read, slv_write, mem_read, mem_write, m_to | m_unm);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus.bus_address = 16'h0000; bus.bus_data_tx = 8'h00;
        bus.bus_read = 1'b0; bus.bus_write = 1'b0;
        slv_wait = '0; mem_wait = 1'b0; mem_data_rx = 8'h00; slv_data_rx = '0;
        model_reset();
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (err_irq !== 1'b0) begin
            failures++;
            $display("FAIL reset err_irq got=%b exp=0", err_irq);
        end
        @(posedge clk); #1;
        run_txn(16'hFFF0, 0, 8'h00, 0, "reset_status");
        run_txn(16'hFFF1, 0, 8'h00, 0, "reset_tocount");
    endtask

    task automatic test_mem_read();
        run_txn(16'h1234, 0, 8'h00, 3, "mem_read");
        run_txn(16'h8001, 2, 8'h5A, 1, "mem_rw_as_write");
    endtask

    task automatic test_slot_write();
        run_txn(16'hFF21, 1, 8'h3C, 0, "slot_write");
        run_txn(16'hFF3E, 0, 8'h00, 2, "slot_read");
    endtask

    task automatic test_timeout();
        run_txn(16'hFF10, 0, 8'h00, 100, "timeout");
        run_txn(16'hFFF0, 0, 8'h00, 0, "status_after_timeout");
        run_txn(16'hFFF1, 0, 8'h00, 0, "tocount_after_timeout");
    endtask

    task automatic test_unmapped();
        run_txn(16'hFFF0, 1, 8'h01, 0, "clear_timeout");
        run_txn(16'hFF50, 0, 8'h00, 0, "unmapped_read");
        run_txn(16'hFFF0, 0, 8'h00, 0, "status_unmapped");
        run_txn(16'hFFF0, 1, 8'h02, 0, "clear_unmapped");
        run_txn(16'hFFF7, 0, 8'h00, 0, "status_reserved");
    endtask

    task automatic test_near_timeout();
        run_txn(16'hFF00, 0, 8'h00, TO - 1, "near_timeout");
        run_txn(16'hFF04, 0, 8'h00, TO, "at_limit");
        run_txn(16'hFFF0, 0, 8'h00, 0, "status_no_timeout");
    endtask

    task automatic test_random();
        logic [15:0] a;
        int cls, st;
        for (int n = 0; n < 200; n++) begin
            cls = $urandom_range(0, 3);
            st  = 0;
            case (cls)
                0: begin a = {8'($urandom_range(0, 254)), 8'($urandom)}; st = $urandom_range(0, 3); end
                1: begin a = {8'hFF, 4'($urandom_range(0, NS - 1)), 4'($urandom)}; st = $urandom_range(0, TO + 2); end
                2: a = {8'hFF, 4'hF, 4'($urandom_range(0, 14))};
                default: a = {8'hFF, 4'($urandom_range(NS, 14)), 4'($urandom)};
            endcase
            run_txn(a, $urandom_range(0, 2), 8'($urandom), st, "random");
        end
    endtask

    task automatic test_async_reset();
        run_txn(16'hFF30, 0, 8'h00, 50, "pre_reset_timeout");
        bus.bus_address = 16'hFF20; bus.bus_read = 1'b1; bus.bus_write = 1'b0;
        slv_wait = 4'b0100;
        repeat (4) @(posedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (err_irq !== 1'b0) begin
            failures++;
            $display("FAIL async_reset err_irq got=%b exp=0", err_irq);
        end
        bus.bus_address = 16'hFFF0;
        #1;
        checks++;
        if (bus.bus_data_rx !== 8'h00) begin
            failures++;
            $display("FAIL async_reset status got=%h exp=00", bus.bus_data_rx);
        end
        bus.bus_address = 16'hFFF1;
        #1;
        checks++;
        if (bus.bus_data_rx !== 8'h00) begin
            failures++;
            $display("FAIL async_reset tocount got=%h exp=00", bus.bus_data_rx);
        end
        model_reset();
        @(posedge clk); #1;
        bus.bus_read = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_txn(16'hFF20, 0, 8'h00, 2, "post_reset_read");
        run_txn(16'hFFF0, 0, 8'h00, 0, "post_reset_status");
    endtask

    initial begin
        test_reset();
        test_mem_read();
        test_slot_write();
        test_timeout();
        test_unmapped();
        test_near_timeout();
        test_random();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
